alignment_result_packer: RTL and testbench
==========================================

Name: alignment_result_packer

Overview:
Receive-side counterpart of the lane-parallel record distributor. Eight processing lanes each return a result record {pos[2:0], nucl_alig[31:0]}. The block buffers each lane's result, arbitrates round-robin and tags each record with its lane index. Records go into an output FIFO and stream out one per cycle on a valid/ready interface toward the result writer, with a per-batch completion pulse.

Parameters:
LANES, 8, number of input lanes (power of 2; lane index width LW = log2(LANES))
POS_W, 3, width of pos field
DATA_W, 32, width of nucl_alig field
DEPTH, 16, output FIFO entries (power of 2, >= 2)
CNT_W, 16, width of rec_count

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  asynchronous, active-high
in_valid  in  LANES  per-lane record valid
in_ready  out  LANES  per-lane ready
in_data  in  LANES*(POS_W+DATA_W)  lane i record at bits [i*35 +: 35], packed {pos, nucl_alig}
out_valid  out  1  FIFO head valid
out_ready  in  1  downstream accepts head
out_data  out  LW+POS_W+DATA_W  {lane[2:0], pos[2:0], nucl_alig[31:0]} = 38 bits
rec_count  out  CNT_W  total records popped, wraps at 2^CNT_W
batch_done  out  1  one-cycle pulse per LANES records popped

Behaviour:
- Clock and reset: clock clk. Reset reset is asynchronous and active-high; all registers clear immediately on assertion.
- Reset values:
  - hold_full all 0; rr_ptr 0; FIFO empty (wr_ptr = rd_ptr = count = 0).
  - out_valid 0; out_data 0; rec_count 0; batch_done 0; batch counter 0.
  - in_ready reads all-ones during and after reset.
- Reset mid-operation: every held and FIFO record is discarded, with no partial output. A handshake in the edge coinciding with reset is lost.
- Per-lane holding register:
  - in_ready[i] = ~hold_full[i] (combinational from the register only, no path from in_valid).
  - When in_valid[i] & in_ready[i] at an edge, capture in_data slice i and set hold_full[i].
  - hold_full[i] clears the edge lane i is granted.
  - A lane cannot reload in its grant cycle, so per-lane throughput is 1 per 2 cycles. Aggregate throughput is 1 per cycle.
- Arbiter:
  - Active when any hold_full is set and count < DEPTH (registered count; no credit from a same-cycle pop).
  - Grants exactly one lane: the first set hold_full at index >= rr_ptr, wrapping modulo LANES.
  - On grant: push {grant_idx, hold[grant_idx]} to the FIFO and set rr_ptr <= (grant_idx+1) mod LANES.
  - With no grant, rr_ptr holds.
- FIFO:
  - out_valid = (count != 0); out_data = mem[rd_ptr], registered memory read, head stable while out_valid & ~out_ready.
  - Pop on out_valid & out_ready.
  - Push+pop in the same cycle: count unchanged.
  - Pointers wrap at DEPTH.
  - When full, no grants occur; holding registers stay full and in_ready stays low, giving backpressure with no data loss.
  - Pop when empty is impossible (out_valid=0). Ready without valid is ignored.
- Latency: handshake at edge k, hold at k, grant and push at edge k+1, out_valid high after k+1 when the FIFO was empty. Minimum in-to-out latency is 1 cycle plus the arbitration wait.
- Counters:
  - rec_count += 1 per pop.
  - batch counter counts pops 0..LANES-1. On the pop bringing it to LANES, it returns to 0 and batch_done is asserted for exactly the next cycle (registered).
- Ordering: no loss, no duplication. Records from a given lane leave in arrival order. Inter-lane order follows grant order.

Test Plan:
1. Reset, then in_valid=8'h01 with pos=3, nucl=32'hDEADBEEF for one cycle; out_ready=1 -> out_valid rises 1 edge after handshake, out_data={3'd0,3'd3,32'hDEADBEEF}, rec_count=1, in_ready[0] low for exactly 1 cycle.
2. All 8 lanes valid in the same cycle with nucl=lane*32'h11111111, out_ready=1 -> outputs lanes 0..7 in order on 8 consecutive cycles; batch_done pulses once, 1 cycle after the 8th pop; rec_count=8.
3. rr_ptr=5 (after granting lane 4), lanes 2 and 6 held -> lane 6 granted first, then lane 2 (wrap).
4. out_ready=0 with continuous all-lane traffic -> FIFO fills to 16, out_valid steady, head unchanged; then 8 further records held and in_ready=8'h00. Release out_ready -> all 24 records emerge, none lost or duplicated, per-lane order preserved.
5. Simultaneous push and pop at count=16: first release out_ready so count drops to 15 -> same-cycle push/pop keeps count at 15; at count=16 no grant occurs even with out_ready=1.
6. Assert reset asynchronously mid-burst with 5 FIFO entries and 3 held -> out_valid, rec_count and batch_done go 0 immediately, in_ready=8'hFF; post-reset output contains only newly injected records.

Source files
------------

// File: rtl/alignment_result_packer.sv
// Gathers per-lane alignment results, arbitrates them round-robin into a lane-tagged
// output FIFO, and streams them out with a running record count and batch pulse.

module alignment_result_lane #(
  parameter int REC_W = 35
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [REC_W-1:0] in_data,
  input  logic             grant,
  output logic             in_ready,
  output logic             full,
  output logic [REC_W-1:0] data
);
  assign in_ready = ~full;

  // Load and grant are mutually exclusive: loading needs an empty slot, a grant needs a full one.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      full <= 1'b0;
      data <= '0;
    end else if (in_valid && !full) begin
      full <= 1'b1;
      data <= in_data;
    end else if (grant) begin
      full <= 1'b0;
    end
  end
endmodule

module alignment_result_packer #(
  parameter int LANES  = 8,
  parameter int POS_W  = 3,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16,
  parameter int CNT_W  = 16
) (
  input  logic                                     clk,
  input  logic                                     reset,
  input  logic [LANES-1:0]                         in_valid,
  output logic [LANES-1:0]                         in_ready,
  input  logic [LANES*(POS_W+DATA_W)-1:0]          in_data,
  output logic                                     out_valid,
  input  logic                                     out_ready,
  output logic [$clog2(LANES)+POS_W+DATA_W-1:0]    out_data,
  output logic [CNT_W-1:0]                         rec_count,
  output logic                                     batch_done
);
  localparam int LW    = $clog2(LANES);
  localparam int REC_W = POS_W + DATA_W;
  localparam int OUT_W = LW + REC_W;
  localparam int AW    = $clog2(DEPTH);
  localparam logic [LW-1:0] ONE_L   = 1;
  localparam logic [AW-1:0] ONE_A   = 1;
  localparam logic [AW:0]   DEPTH_C = DEPTH;

  logic [LANES-1:0]            hold_full, grant;
  logic [LANES-1:0][REC_W-1:0] hold_data;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    alignment_result_lane #(.REC_W(REC_W)) u_lane (
      .clk      (clk),
      .reset    (reset),
      .in_valid (in_valid[i]),
      .in_data  (in_data[i*REC_W +: REC_W]),
      .grant    (grant[i]),
      .in_ready (in_ready[i]),
      .full     (hold_full[i]),
      .data     (hold_data[i])
    );
  end

  logic [LW-1:0]    rr_ptr, grant_idx, cand;
  logic             push, pop;
  logic [AW:0]      count, count_lo;
  logic [AW-1:0]    wr_ptr, rd_ptr, rd_nxt;
  logic [OUT_W-1:0] mem [DEPTH];
  logic [OUT_W-1:0] push_rec, head_nxt;
  logic [LW-1:0]    batch_cnt;

  // Search starts at rr_ptr and wraps; the registered count gives no credit for a same-cycle pop.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    cand      = '0;
    push      = 1'b0;
    if ((|hold_full) && (count < DEPTH_C)) begin
      for (int i = 0; i < LANES; i++) begin
        cand = rr_ptr + LW'(i);
        if (!push && hold_full[cand]) begin
          push      = 1'b1;
          grant_idx = cand;
        end
      end
    end
    if (push) grant[grant_idx] = 1'b1;
  end

  assign push_rec  = {grant_idx, hold_data[grant_idx]};
  assign out_valid = (count != '0);
  assign pop       = out_valid & out_ready;
  assign rd_nxt    = pop ? rd_ptr + ONE_A : rd_ptr;
  assign count_lo  = count - {{AW{1'b0}}, pop};
  // A push into a FIFO that is (or is about to be) empty becomes the new head directly.
  assign head_nxt  = (push && count_lo == '0) ? push_rec : mem[rd_nxt];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_rec;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr   <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      out_data <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + ONE_A;
        rr_ptr <= grant_idx + ONE_L;
      end
      if (pop) rd_ptr <= rd_ptr + ONE_A;
      count    <= count_lo + {{AW{1'b0}}, push};
      out_data <= head_nxt;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rec_count  <= '0;
      batch_cnt  <= '0;
      batch_done <= 1'b0;
    end else begin
      batch_done <= pop && (batch_cnt == LW'(LANES - 1));
      if (pop) begin
        rec_count <= rec_count + CNT_W'(1);
        batch_cnt <= batch_cnt + ONE_L;
      end
    end
  end
endmodule

// File: tb/tb_alignment_result_packer.sv
// Bench for alignment_result_packer: table-driven burst check, directed sequences,
// and a lane-tagged scoreboard covering loss, duplication and per-lane order.

module tb_alignment_result_packer;
  logic         clk = 1'b0;
  logic         reset;
  logic [7:0]   in_valid, in_ready;
  logic [279:0] in_data;
  logic         out_valid, out_ready;
  logic [37:0]  out_data;
  logic [15:0]  rec_count;
  logic         batch_done;

  alignment_result_packer dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .rec_count(rec_count), .batch_done(batch_done)
  );

  always #5 clk = ~clk;

  int n_vec = 0, n_err = 0, npop = 0, nacc = 0, bd_seen = 0, gseq = 0;
  logic [37:0] sbq[$];
  logic [7:0]  took;

  typedef struct {
    logic [7:0]  iv;
    logic        ev;
    logic [2:0]  elane;
    logic [15:0] erc;
    logic        ebd;
    logic [7:0]  erdy;
  } vec_t;
  vec_t tv[11];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic set_lane(input int i, input logic [2:0] pos, input logic [31:0] nucl);
    in_data[i*35 +: 35] = {pos, nucl};
  endtask

  task automatic new_lane(input int i);
    gseq++;
    set_lane(i, 3'(gseq), 32'hA000_0000 | (32'(i) << 16) | 32'(gseq));
  endtask

  task automatic sb_check();
    int idx = -1;
    for (int k = 0; k < sbq.size(); k++)
      if (sbq[k][37:35] == out_data[37:35]) begin
        idx = k;
        break;
      end
    npop++;
    if (idx < 0) begin
      n_vec++;
      n_err++;
      $display("FAIL sb_unexpected: got %0h expected no record", out_data);
    end else begin
      chk("sb_order", 64'(out_data), 64'(sbq[idx]));
      sbq.delete(idx);
    end
  endtask

  // Observe the handshakes the coming edge will perform, then advance one cycle.
  task automatic tick();
    for (int i = 0; i < 8; i++) begin
      took[i] = in_valid[i] & in_ready[i];
      if (took[i]) begin
        sbq.push_back({3'(i), in_data[i*35 +: 35]});
        nacc++;
      end
    end
    if (out_valid && out_ready) sb_check();
    if (batch_done) bd_seen++;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    sbq.delete();
  endtask

  task automatic drain(input int maxc);
    int c = 0;
    while ((sbq.size() != 0 || out_valid) && c < maxc) begin
      tick();
      c++;
    end
    if (c >= maxc) begin
      n_vec++;
      n_err++;
      $display("FAIL drain_timeout: got %0d pending expected 0", sbq.size());
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [37:0] head_exp;
    tv[0]  = '{8'hFF, 1'b0, 3'd0, 16'd0, 1'b0, 8'h00};
    tv[1]  = '{8'h00, 1'b1, 3'd0, 16'd0, 1'b0, 8'h01};
    tv[2]  = '{8'h00, 1'b1, 3'd1, 16'd1, 1'b0, 8'h03};
    tv[3]  = '{8'h00, 1'b1, 3'd2, 16'd2, 1'b0, 8'h07};
    tv[4]  = '{8'h00, 1'b1, 3'd3, 16'd3, 1'b0, 8'h0F};
    tv[5]  = '{8'h00, 1'b1, 3'd4, 16'd4, 1'b0, 8'h1F};
    tv[6]  = '{8'h00, 1'b1, 3'd5, 16'd5, 1'b0, 8'h3F};
    tv[7]  = '{8'h00, 1'b1, 3'd6, 16'd6, 1'b0, 8'h7F};
    tv[8]  = '{8'h00, 1'b1, 3'd7, 16'd7, 1'b0, 8'hFF};
    tv[9]  = '{8'h00, 1'b0, 3'd0, 16'd8, 1'b1, 8'hFF};
    tv[10] = '{8'h00, 1'b0, 3'd0, 16'd8, 1'b0, 8'hFF};

    reset = 1'b1; in_valid = '0; out_ready = 1'b0; in_data = '0; took = '0;
    @(posedge clk);
    #1;
    chk("rst_in_ready_during", 64'(in_ready), 64'hFF);
    chk("rst_out_valid_during", 64'(out_valid), 64'h0);
    reset = 1'b0;
    chk("rst_out_data", 64'(out_data), 64'h0);
    chk("rst_rec_count", 64'(rec_count), 64'h0);
    chk("rst_batch_done", 64'(batch_done), 64'h0);
    chk("rst_in_ready", 64'(in_ready), 64'hFF);

    // Single record on lane 0
    out_ready = 1'b1;
    in_valid = 8'h01;
    set_lane(0, 3'd3, 32'hDEADBEEF);
    tick();
    in_valid = 8'h00;
    chk("t1_in_ready_low", 64'(in_ready), 64'hFE);
    chk("t1_out_valid_early", 64'(out_valid), 64'h0);
    tick();
    chk("t1_out_valid", 64'(out_valid), 64'h1);
    chk("t1_out_data", 64'(out_data), 64'({3'd0, 3'd3, 32'hDEADBEEF}));
    chk("t1_in_ready_back", 64'(in_ready), 64'hFF);
    tick();
    chk("t1_rec_count", 64'(rec_count), 64'h1);
    chk("t1_out_valid_after", 64'(out_valid), 64'h0);

    // All lanes at once: table-driven
    do_reset();
    for (int i = 0; i < 8; i++) set_lane(i, 3'(i), 32'(i) * 32'h11111111);
    for (int r = 0; r < 11; r++) begin
      in_valid = tv[r].iv;
      tick();
      chk($sformatf("t2_valid_%0d", r), 64'(out_valid), 64'(tv[r].ev));
      if (tv[r].ev)
        chk($sformatf("t2_data_%0d", r), 64'(out_data),
            64'({tv[r].elane, tv[r].elane, 32'(tv[r].elane) * 32'h11111111}));
      chk($sformatf("t2_rc_%0d", r), 64'(rec_count), 64'(tv[r].erc));
      chk($sformatf("t2_bd_%0d", r), 64'(batch_done), 64'(tv[r].ebd));
      chk($sformatf("t2_rdy_%0d", r), 64'(in_ready), 64'(tv[r].erdy));
    end

    // Round-robin wrap: grant lane 4, then lanes 2 and 6 held
    do_reset();
    in_valid = 8'h10;
    set_lane(4, 3'd1, 32'h4444_0001);
    tick();
    in_valid = 8'h00;
    tick();
    chk("t3_lane4", 64'(out_data[37:35]), 64'd4);
    in_valid = 8'h44;
    set_lane(2, 3'd2, 32'h2222_0002);
    set_lane(6, 3'd6, 32'h6666_0006);
    tick();
    in_valid = 8'h00;
    tick();
    chk("t3_first_lane6", 64'(out_data[37:35]), 64'd6);
    tick();
    chk("t3_then_lane2", 64'(out_data[37:35]), 64'd2);
    drain(20);

    // Backpressure fill
    do_reset();
    npop = 0; nacc = 0; bd_seen = 0;
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) new_lane(i);
    in_valid = 8'hFF;
    tick();
    head_exp = sbq[0];
    for (int c = 0; c < 40; c++) begin
      for (int i = 0; i < 8; i++) if (took[i]) new_lane(i);
      tick();
      chk("t4_out_valid", 64'(out_valid), 64'h1);
      chk("t4_head", 64'(out_data), 64'(head_exp));
    end
    chk("t4_accepted", 64'(nacc), 64'd24);
    chk("t4_in_ready", 64'(in_ready), 64'h00);

    // Full FIFO: pop frees a slot only for the following cycle
    in_valid = 8'h00;
    out_ready = 1'b1;
    tick();
    chk("t5_no_grant_full", 64'($countones(in_ready)), 64'd0);
    tick();
    chk("t5_push_pop_1", 64'($countones(in_ready)), 64'd1);
    tick();
    chk("t5_push_pop_2", 64'($countones(in_ready)), 64'd2);
    out_ready = 1'b0;
    for (int c = 0; c < 3; c++) tick();
    chk("t5_refill_one", 64'($countones(in_ready)), 64'd3);
    out_ready = 1'b1;
    drain(100);
    tick();
    chk("t4_popped", 64'(npop), 64'd24);
    chk("t4_rec_count", 64'(rec_count), 64'd24);
    chk("t4_batches", 64'(bd_seen), 64'd3);
    chk("t4_sb_empty", 64'(sbq.size()), 64'd0);

    // Async reset with 5 queued and 3 held
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) new_lane(i);
    in_valid = 8'hFF;
    tick();
    in_valid = 8'h00;
    for (int c = 0; c < 5; c++) tick();
    chk("t6_pre_ready", 64'($countones(in_ready)), 64'd5);
    #2 reset = 1'b1;
    #1;
    chk("t6_out_valid", 64'(out_valid), 64'h0);
    chk("t6_rec_count", 64'(rec_count), 64'h0);
    chk("t6_batch_done", 64'(batch_done), 64'h0);
    chk("t6_in_ready", 64'(in_ready), 64'hFF);
    sbq.delete();
    @(posedge clk);
    #1;
    reset = 1'b0;
    npop = 0;
    out_ready = 1'b1;
    new_lane(1);
    new_lane(3);
    in_valid = 8'h0A;
    tick();
    in_valid = 8'h00;
    drain(50);
    chk("t6_post_pops", 64'(npop), 64'd2);
    chk("t6_post_rc", 64'(rec_count), 64'd2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
